// File: rtl/baby_core.sv
// baby_core: a small accumulator machine with a 3-cycle instruction loop
// (increment CI, fetch into PI, execute) against an external single-port store.
//
// Ports
//    clock         rising-edge clock
//    reset_n_i     synchronous active-low reset
//    run_en_i      free-run enable, sampled only between instructions
//    step_i        single-instruction request (used only with BABY_SINGLE_STEP_EN)
//    ram_data_i    store read data, combinational from ram_addr_o
//    ram_data_o    store write data, always the accumulator
//    ram_addr_o    store address
//    ram_rw_en_o   store write strobe (1 = write)
//    stop_lamp_o   high while halted by STP
//    instr_done_o  one-cycle pulse in the execute cycle of each instruction
//
// Optional feature: define BABY_SINGLE_STEP_EN to let a rising edge of step_i
// start one instruction while run_en_i is low.
module baby_core #(
   parameter int unsigned WORD_W = 32,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clock,
   input  logic              reset_n_i,
   input  logic              run_en_i,
   input  logic              step_i,
   input  logic [WORD_W-1:0] ram_data_i,
   output logic [WORD_W-1:0] ram_data_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic              ram_rw_en_o,
   output logic              stop_lamp_o,
   output logic              instr_done_o
);

   localparam int unsigned F_LSB = ADDR_W + 8;

   typedef enum logic [1:0] {
      S_INC   = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] ci, ci_nxt;
   logic [WORD_W-1:0] pi, pi_nxt;
   logic [WORD_W-1:0] a, a_nxt;
   logic [2:0]        func;
   logic [ADDR_W-1:0] operand;
   logic [ADDR_W-1:0] s_addr;
   logic              start;

   assign func    = pi[F_LSB+2:F_LSB];
   assign operand = pi[ADDR_W-1:0];
   assign s_addr  = ram_data_i[ADDR_W-1:0];

   // PI bits outside the function/operand fields carry no meaning
   logic unused_pi;
   assign unused_pi = ^pi;

`ifdef BABY_SINGLE_STEP_EN
   // Previous step_i level, for rising-edge detection
   logic step_q;

   always_ff @(posedge clock) begin
      if (!reset_n_i) step_q <= 1'b0;
      else            step_q <= step_i;
   end

   assign start = run_en_i | (step_i & ~step_q);
`else
   logic unused_step;
   assign unused_step = step_i;
   assign start       = run_en_i;
`endif

   // State and architectural registers
   always_ff @(posedge clock) begin
      if (!reset_n_i) begin
         state <= S_INC;
         ci    <= '0;
         pi    <= '0;
         a     <= '0;
      end else begin
         state <= state_nxt;
         ci    <= ci_nxt;
         pi    <= pi_nxt;
         a     <= a_nxt;
      end
   end

   // Next-state, datapath and store control
   always_comb begin
      state_nxt    = state;
      ci_nxt       = ci;
      pi_nxt       = pi;
      a_nxt        = a;
      ram_addr_o   = '0;
      ram_rw_en_o  = 1'b0;
      instr_done_o = 1'b0;

      case (state)
         S_INC: begin
            if (start) begin
               ci_nxt    = ci + ADDR_W'(1);
               state_nxt = S_FETCH;
            end
         end
         S_FETCH: begin
            ram_addr_o = ci;
            pi_nxt     = ram_data_i;
            state_nxt  = S_EXEC;
         end
         S_EXEC: begin
            ram_addr_o   = operand;
            instr_done_o = 1'b1;
            state_nxt    = S_INC;
            case (func)
               3'd0: ci_nxt = s_addr;
               3'd1: ci_nxt = ci + s_addr;
               3'd2: a_nxt  = '0 - ram_data_i;
               // A reset edge in this cycle must not leave a write behind
               3'd3: ram_rw_en_o = reset_n_i;
               3'd4,
               3'd5: a_nxt  = a - ram_data_i;
               3'd6: begin
                  if (a[WORD_W-1]) ci_nxt = ci + ADDR_W'(1);
               end
               default: state_nxt = S_STOP;
            endcase
         end
         default: begin
            state_nxt = S_STOP;
         end
      endcase
   end

   assign ram_data_o  = a;
   assign stop_lamp_o = (state == S_STOP);

endmodule

// File: tb/tb_baby_core.sv
// tb_baby_core: randomized and directed programs for baby_core. An ISA-level
// model predicts each instruction's store access and accumulator effect; a
// monitor checks them whenever instr_done_o pulses.
module tb_baby_core;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned DEPTH  = 32;

   logic              clock = 1'b0;
   logic              reset_n_i;
   logic              run_en_i;
   logic              step_i;
   logic [WORD_W-1:0] ram_data_i;
   logic [WORD_W-1:0] ram_data_o;
   logic [ADDR_W-1:0] ram_addr_o;
   logic              ram_rw_en_o;
   logic              stop_lamp_o;
   logic              instr_done_o;

   baby_core #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) dut (
      .clock        (clock),
      .reset_n_i    (reset_n_i),
      .run_en_i     (run_en_i),
      .step_i       (step_i),
      .ram_data_i   (ram_data_i),
      .ram_data_o   (ram_data_o),
      .ram_addr_o   (ram_addr_o),
      .ram_rw_en_o  (ram_rw_en_o),
      .stop_lamp_o  (stop_lamp_o),
      .instr_done_o (instr_done_o)
   );

   always #5 clock = ~clock;

   // External store
   logic [WORD_W-1:0] ram [DEPTH];
   assign ram_data_i = ram[ram_addr_o];
   always @(posedge clock) if (ram_rw_en_o) ram[ram_addr_o] = ram_data_o;

   typedef struct {
      logic [ADDR_W-1:0] op;
      logic              rw;
      logic [WORD_W-1:0] a_before;
      logic [WORD_W-1:0] a_after;
   } exp_t;

   exp_t              exp_q[$];
   int                n_cmp  = 0;
   int                n_fail = 0;
   bit                mon_en = 1'b0;
   bit                chk_after = 1'b0;
   logic [WORD_W-1:0] pend_a;
   int                rw_cycles = 0;

   // Reference machine state
   logic [WORD_W-1:0] mdl_mem [DEPTH];
   int unsigned       mdl_ci;
   logic [WORD_W-1:0] mdl_a;

   task automatic check(input string name, input logic [WORD_W-1:0] act,
                        input logic [WORD_W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [WORD_W-1:0] mk(input int unsigned f, input int unsigned op);
      return WORD_W'((f << (ADDR_W + 8)) | op);
   endfunction

   task automatic load(input int unsigned addr, input logic [WORD_W-1:0] val);
      ram[addr]     = val;
      mdl_mem[addr] = val;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < DEPTH; i++) load(i, '0);
   endtask

   // Run the reference machine for up to k instructions, queueing expectations
   task automatic gen(input int k, output int cnt, output bit stopped);
      int unsigned       f, op;
      logic [WORD_W-1:0] ins, s;
      exp_t              e;
      cnt = 0;
      stopped = 1'b0;
      while (cnt < k && !stopped) begin
         mdl_ci = (mdl_ci + 1) % DEPTH;
         ins = mdl_mem[mdl_ci];
         f   = (ins >> (ADDR_W + 8)) & 7;
         op  = ins % DEPTH;
         s   = mdl_mem[op];
         e.op = ADDR_W'(op);
         e.rw = (f == 3);
         e.a_before = mdl_a;
         case (f)
            0: mdl_ci = s % DEPTH;
            1: mdl_ci = (mdl_ci + (s % DEPTH)) % DEPTH;
            2: mdl_a = -s;
            3: mdl_mem[op] = mdl_a;
            4, 5: mdl_a = mdl_a - s;
            6: if ($signed(mdl_a) < 0) mdl_ci = (mdl_ci + 1) % DEPTH;
            default: stopped = 1'b1;
         endcase
         e.a_after = mdl_a;
         exp_q.push_back(e);
         cnt++;
      end
   endtask

   // Monitor: compare each completed instruction against the queue head
   always @(negedge clock) begin
      if (ram_rw_en_o) rw_cycles++;
      if (chk_after) begin
         check("acc_after", ram_data_o, pend_a);
         chk_after = 1'b0;
      end
      if (mon_en && instr_done_o) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 1'b1, 1'b0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("operand_addr", WORD_W'(ram_addr_o), WORD_W'(e.op));
            check("rw_strobe", WORD_W'(ram_rw_en_o), WORD_W'(e.rw));
            check("acc_before", ram_data_o, e.a_before);
            pend_a    = e.a_after;
            chk_after = 1'b1;
         end
      end
   end

   // Enter reset; memory may be loaded before release_reset
   task automatic enter_reset();
      reset_n_i = 1'b0;
      run_en_i  = 1'b0;
      step_i    = 1'b0;
      repeat (2) @(negedge clock);
      mdl_ci = 0;
      mdl_a  = '0;
      exp_q.delete();
      chk_after = 1'b0;
      rw_cycles = 0;
      check("rst_data", ram_data_o, '0);
      check("rst_addr", WORD_W'(ram_addr_o), '0);
      check("rst_rw", WORD_W'(ram_rw_en_o), '0);
      check("rst_lamp", WORD_W'(stop_lamp_o), '0);
      check("rst_done", WORD_W'(instr_done_o), '0);
   endtask

   task automatic run_prog(input int k, output bit stopped);
      int cnt, seen, budget;
      gen(k, cnt, stopped);
      mon_en    = 1'b1;
      reset_n_i = 1'b1;
      run_en_i  = 1'b1;
      seen   = 0;
      budget = 3 * cnt + 10;
      while (seen < cnt && budget > 0) begin
         @(negedge clock);
         budget--;
         if (instr_done_o) begin
            seen++;
            if (seen == cnt) run_en_i = 1'b0;
         end
      end
      check("done_count", WORD_W'(seen), WORD_W'(cnt));
      repeat (6) @(negedge clock);
      check("stop_lamp", WORD_W'(stop_lamp_o), WORD_W'(stopped));
      check("queue_drained", WORD_W'(exp_q.size()), '0);
      if (stopped) check("stop_addr", WORD_W'(ram_addr_o), '0);
      mon_en = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit stopped;
      int dones;
      reset_n_i = 1'b0;
      run_en_i  = 1'b0;
      step_i    = 1'b0;

      // LDN/SUB/STO/STP sequence
      enter_reset();
      clear_mem();
      load(1, mk(2, 20)); load(2, mk(4, 21)); load(3, mk(3, 22)); load(4, mk(7, 0));
      load(20, 32'd3); load(21, 32'd4);
      run_prog(10, stopped);
      check("sto_result", ram[22], 32'hFFFF_FFF9);
      check("sto_rw_pulses", WORD_W'(rw_cycles), 32'd1);
      check("sto_stopped", WORD_W'(stopped), 32'd1);

      // CMP with negative accumulator skips to 7; positive proceeds to 6
      for (int neg = 0; neg < 2; neg++) begin
         enter_reset();
         clear_mem();
         load(1, mk(2, 20));
         load(20, neg ? 32'd1 : 32'hFFFF_FFFF);
         for (int i = 2; i <= 4; i++) load(i, mk(4, 21));
         load(5, mk(6, 0)); load(6, mk(7, 10)); load(7, mk(7, 11));
         run_prog(10, stopped);
      end

      // Wrap: CI 31 -> 0, JRP from address 0 lands at 3, next fetch 4
      enter_reset();
      clear_mem();
      load(1, mk(0, 20)); load(20, 32'd30);
      load(31, mk(0, 21)); load(21, 32'd31);
      load(0, mk(1, 22)); load(22, 32'd3);
      load(4, mk(7, 12));
      run_prog(10, stopped);

      // Random programs, STP made less frequent
      for (int p = 0; p < 20; p++) begin
         enter_reset();
         for (int i = 0; i < DEPTH; i++) begin
            logic [WORD_W-1:0] w;
            w = $urandom;
            if (((w >> (ADDR_W + 8)) & 7) == 7 && ($urandom % 4) != 0)
               w = (w & ~mk(7, 0)) | mk($urandom % 7, 0);
            load(i, w);
         end
         run_prog(40, stopped);
      end

      // run_en dropped mid-instruction, then reset during STO execute
      enter_reset();
      clear_mem();
      load(1, mk(2, 20)); load(2, mk(3, 22));
      load(20, 32'd5); load(22, 32'hA5A5_A5A5);
      reset_n_i = 1'b1;
      run_en_i  = 1'b1;
      @(negedge clock);
      run_en_i = 1'b0;
      @(negedge clock);
      check("ldn_done", WORD_W'(instr_done_o), 32'd1);
      check("ldn_addr", WORD_W'(ram_addr_o), 32'd20);
      @(negedge clock);
      check("ldn_acc", ram_data_o, 32'hFFFF_FFFB);
      dones = 0;
      repeat (6) begin
         @(negedge clock);
         if (instr_done_o) dones++;
      end
      check("hold_no_done", WORD_W'(dones), '0);
      run_en_i = 1'b1;
      repeat (2) @(negedge clock);
      check("sto_exec_rw", WORD_W'(ram_rw_en_o), 32'd1);
      check("sto_exec_addr", WORD_W'(ram_addr_o), 32'd22);
      reset_n_i = 1'b0;
      #1;
      check("sto_rw_suppressed", WORD_W'(ram_rw_en_o), '0);
      @(negedge clock);
      check("sto_mem_kept", ram[22], 32'hA5A5_A5A5);
      check("post_rst_data", ram_data_o, '0);
      check("post_rst_addr", WORD_W'(ram_addr_o), '0);
      check("post_rst_done", WORD_W'(instr_done_o), '0);
      check("post_rst_lamp", WORD_W'(stop_lamp_o), '0);

      // step_i held high with run_en low
      enter_reset();
      clear_mem();
      reset_n_i = 1'b1;
      step_i    = 1'b1;
      dones = 0;
      repeat (10) begin
         @(negedge clock);
         if (instr_done_o) dones++;
      end
      step_i = 1'b0;
`ifdef BABY_SINGLE_STEP_EN
      check("step_done_count", WORD_W'(dones), 32'd1);
`else
      check("step_done_count", WORD_W'(dones), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
